regfile_wb32: RTL and testbench
===============================

// Module: regfile_wb32
// PURPOSE
//  32 x DATA_W general-purpose register file. It consumes the 5-bit write-register
//  address chosen by the write-back destination mux (rt / rd / $31 / spare). Two
//  combinational read ports feed the ID stage. One synchronous write port is driven
//  by the WB stage. Register $0 reads as zero. A write-through bypass lets a WB write
//  and an ID read of the same register in one cycle return the new value.
//  A debug read port serves the VGA/LED register viewer.
// PARAMETERS
//  DATA_W    32  register width in bits
//  ADDR_W     5  register address width (2**ADDR_W entries)
// PORTS
//  clk       in   1       system clock; all state updates on posedge
//  rst       in   1       asynchronous, active-high reset
//  rs_addr   in   ADDR_W  read port A address
//  rt_addr   in   ADDR_W  read port B address
//  rs_data   out  DATA_W  read port A data (combinational)
//  rt_data   out  DATA_W  read port B data (combinational)
//  wb_addr   in   ADDR_W  write address from the WB destination mux
//  wb_data   in   DATA_W  write data
//  wb_en     in   1       write enable (RegWrite from WB stage)
//  dbg_addr  in   ADDR_W  debug read address
//  dbg_data  out  DATA_W  debug read data (registered, 1-cycle latency)
//  wr_count  out  16      count of committed writes; wraps
// BEHAVIOUR
//  - Reset (async assert, takes effect immediately): all 32 entries = 0,
//    dbg_data = 0, wr_count = 0. rs_data/rt_data then read 0 for any address.
//  - Write: at posedge, if !rst && wb_en && wb_addr != 0, then
//    mem[wb_addr] <= wb_data and wr_count <= wr_count + 1 (16-bit wrap, FFFF -> 0000).
//  - Writes to $0 are discarded. mem[0] stays 0 and wr_count does not increment.
//  - Read ports A and B are identical and independent. For port A:
//      rs_addr == 0                                     -> 0
//      else wb_en && wb_addr == rs_addr (write-through)  -> wb_data
//      else                                             -> mem[rs_addr]
//  - Both read ports may address the write target at once; both bypass.
//  - Debug port: dbg_data <= (dbg_addr==0) ? 0 : mem[dbg_addr] at each posedge.
//    It reads the pre-write contents of that cycle and has no bypass.
//  - Reset asserted mid-cycle while wb_en is high: the write is lost and the array
//    is cleared. The first posedge after deassertion may write normally.
//  - X on wb_addr while wb_en = 0 must not corrupt the array.
//  - No stall or handshake. Upstream holds wb_en low on bubbles.
// TESTING
//  1 Reset: pulse rst async between edges. Then rs=1, rt=31 -> both 0; dbg(5) -> 0; wr_count = 0.
//  2 Write/read: write $8 = 32'hDEADBEEF. Next cycle rs=8 -> DEADBEEF; wr_count = 1.
//  3 $0 guard: wb_en=1, wb_addr=0, wb_data=FFFFFFFF. Then rs=0 -> 0; wr_count unchanged.
//  4 Bypass: same cycle wb_addr=31, wb_data=0x00400010, rs=rt=31.
//    Both ports = 0x00400010 before the edge; dbg(31) after the edge shows the old value.
//  5 Reset mid-op: write $3 = 0x1234, assert rst before the next edge.
//    $3 reads 0 and wr_count = 0 after release.
//  6 Wrap/stress: 65536 writes to random non-zero addresses, checked against a model.
//    wr_count wraps to 0; every register matches the model.

Source files
------------

// File: rtl/regfile_wb32.sv
// regfile_wb32: 32 x DATA_W general-purpose register file for the pipeline ID/WB stages.
// Latency: rs/rt reads are combinational with WB write-through; the debug read is registered (1 cycle).
// Backpressure: none. Upstream holds wb_en low on bubbles, and every write is accepted.
//
// Ports:
//   clk, rst            system clock and async active-high reset
//   rs_addr / rs_data   read port A (combinational)
//   rt_addr / rt_data   read port B (combinational)
//   wb_addr, wb_data,   synchronous write port from the WB destination mux
//   wb_en
//   dbg_addr / dbg_data debug read for the register viewer (registered, no bypass)
//   wr_count            16-bit count of committed writes; wraps
module regfile_wb32 #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [15:0]       wr_count
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_commit;

  // $0 is hard-wired to zero, so a write to it is dropped and does not count.
  // wb_en is tested first so that an X on wb_addr during a bubble cannot
  // turn into a write.
  assign wr_commit = wb_en && (wb_addr != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_commit) begin
      mem[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_count <= '0;
    end else if (wr_commit) begin
      wr_count <= wr_count + 16'd1;
    end
  end

  // The debug viewer sees the array contents before this cycle's write lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbg_data <= '0;
    end else if (dbg_addr == '0) begin
      dbg_data <= '0;
    end else begin
      dbg_data <= mem[dbg_addr];
    end
  end

  // Write-through lets ID read a value that WB is committing in the same
  // cycle. The $0 check comes first so that a discarded $0 write never leaks
  // through the bypass.
  always_comb begin
    rs_data = mem[rs_addr];
    if (rs_addr == '0) begin
      rs_data = '0;
    end else if (wb_en && (wb_addr == rs_addr)) begin
      rs_data = wb_data;
    end
  end

  always_comb begin
    rt_data = mem[rt_addr];
    if (rt_addr == '0) begin
      rt_data = '0;
    end else if (wb_en && (wb_addr == rt_addr)) begin
      rt_data = wb_data;
    end
  end

endmodule

// File: tb/tb_regfile_wb32.sv
// tb_regfile_wb32: scoreboard bench for regfile_wb32.
// Expected values come from a reference array plus a write counter, and are queued when stimulus is driven.
// They are popped and compared when the DUT output is sampled, away from the clock edge.
module tb_regfile_wb32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  rs_addr = '0;
  logic [4:0]  rt_addr = '0;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        wb_en = 1'b0;
  logic [4:0]  dbg_addr = '0;
  logic [31:0] dbg_data;
  logic [15:0] wr_count;

  logic [31:0] model [32];
  logic [15:0] model_cnt;

  string       tag_q [$];
  logic [31:0] exp_q [$];

  int vectors     = 0;
  int miscompares = 0;

  regfile_wb32 #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .rs_addr  (rs_addr),
    .rt_addr  (rt_addr),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .wb_en    (wb_en),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .wr_count (wr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL sb_underflow: got %h expected nothing queued", obs);
    end else begin
      chk(tag_q.pop_front(), obs, exp_q.pop_front());
    end
  endtask

  function automatic logic [31:0] ref_read(input logic [4:0] a);
    if (a == 5'd0)                   return 32'h0;
    if (wb_en && (wb_addr === a))    return wb_data;
    return model[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    model_cnt = 16'h0;
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] da);
    wb_en    = we;
    wb_addr  = wa;
    wb_data  = wd;
    rs_addr  = ra;
    rt_addr  = rb;
    dbg_addr = da;
  endtask

  // Queue the combinational read expectations for the current inputs, then sample.
  task automatic check_reads(input string tag);
    sb_push({tag, "_rs"}, ref_read(rs_addr));
    sb_push({tag, "_rt"}, ref_read(rt_addr));
    #1;
    sb_check(rs_data);
    sb_check(rt_data);
  endtask

  // One clock: the debug expectation uses pre-write model contents, then the model commits.
  task automatic cycle(input string tag);
    logic [31:0] d_exp;
    d_exp = (dbg_addr == 5'd0) ? 32'h0 : model[dbg_addr];
    sb_push({tag, "_dbg"}, d_exp);
    @(posedge clk);
    if (!rst && wb_en === 1'b1 && wb_addr != 5'd0) begin
      model[wb_addr] = wb_data;
      model_cnt      = model_cnt + 16'd1;
    end
    #1;
    sb_check(dbg_data);
    sb_push({tag, "_cnt"}, {16'h0, model_cnt});
    sb_check({16'h0, wr_count});
  endtask

  initial begin
    logic [4:0]  wa;
    logic [31:0] wd;
    model_clear();

    // 1: async reset pulse between edges (posedges at 5, 15, ...)
    #11 rst = 1'b1;
    #2  rst = 1'b0;
    #1;
    sb_push("rst_dbg", 32'h0);  sb_check(dbg_data);
    sb_push("rst_cnt", 32'h0);  sb_check({16'h0, wr_count});
    @(posedge clk); #1;
    drive(1'b0, 5'd0, 32'h0, 5'd1, 5'd31, 5'd5);
    check_reads("t1");
    cycle("t1");

    // 2: write $8 then read it back
    drive(1'b1, 5'd8, 32'hDEADBEEF, 5'd8, 5'd0, 5'd8);
    check_reads("t2_wr");
    cycle("t2_wr");
    drive(1'b0, 5'd0, 32'h0, 5'd8, 5'd8, 5'd8);
    check_reads("t2_rd");
    cycle("t2_rd");

    // 3: write to $0 is discarded and not counted
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0);
    check_reads("t3_wr");
    cycle("t3_wr");
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd8, 5'd0);
    check_reads("t3_rd");
    cycle("t3_rd");

    // 4: bypass on both ports; debug shows the old $31 across the edge
    drive(1'b1, 5'd31, 32'h11112222, 5'd1, 5'd2, 5'd31);
    check_reads("t4_pre");
    cycle("t4_pre");
    drive(1'b1, 5'd31, 32'h00400010, 5'd31, 5'd31, 5'd31);
    check_reads("t4_byp");
    cycle("t4_byp");
    drive(1'b0, 5'd0, 32'h0, 5'd31, 5'd8, 5'd31);
    check_reads("t4_post");
    cycle("t4_post");

    // 5: reset asserted mid-cycle while a write is pending
    drive(1'b1, 5'd3, 32'h00001234, 5'd3, 5'd8, 5'd3);
    check_reads("t5_wr");
    #2 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd8, 5'd31);
    sb_push("t5_dbg", 32'h0); sb_check(dbg_data);
    sb_push("t5_cnt", 32'h0); sb_check({16'h0, wr_count});
    check_reads("t5_rd");
    // The first edge after release may write.
    drive(1'b1, 5'd5, 32'h00000055, 5'd3, 5'd31, 5'd8);
    check_reads("t5_wr2");
    cycle("t5_wr2");
    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd3, 5'd5);
    check_reads("t5_rd2");
    cycle("t5_rd2");

    // 6: fresh reset, then 65536 random writes with idle X-address bubbles
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    model_clear();
    @(posedge clk); #1;
    for (int i = 0; i < 65536; i++) begin
      wa = 5'($urandom_range(31, 1));
      wd = $urandom;
      drive(1'b1, wa, wd,
            (i % 4 == 0) ? wa : 5'($urandom_range(31, 0)),
            (i % 8 == 1) ? wa : 5'($urandom_range(31, 0)),
            5'($urandom_range(31, 0)));
      check_reads("t6");
      cycle("t6");
      if (i % 64 == 63) begin
        drive(1'b0, 5'bxxxxx, 32'hA5A5A5A5, 5'($urandom_range(31, 0)),
              5'($urandom_range(31, 0)), 5'($urandom_range(31, 0)));
        check_reads("t6_idle");
        cycle("t6_idle");
      end
      if (i == 65534) chk("t6_cnt_ffff", {16'h0, wr_count}, 32'h0000FFFF);
    end
    chk("t6_wrap", {16'h0, wr_count}, 32'h0);
    for (int a = 0; a < 32; a++) begin
      drive(1'b0, 5'd0, 32'h0, 5'(a), 5'(31 - a), 5'(a));
      check_reads("t6_dump");
      cycle("t6_dump");
    end

    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL sb_leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
